// File: rtl/image_translate_stream_if.sv
// image_translate_stream_if: pixel stream bundle (input beat side and shifted output side)
interface image_translate_stream_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3,
    parameter int CW         = 10
);
    logic                           s_valid;
    logic                           s_ready;
    logic [CHANNELS*DATA_WIDTH-1:0] s_data;
    logic                           s_sof;
    logic                           s_eol;
    logic                           m_valid;
    logic                           m_ready;
    logic [CHANNELS*DATA_WIDTH-1:0] m_data;
    logic [CW-1:0]                  m_x;
    logic [CW-1:0]                  m_y;
    logic                           m_inb;
    modport slave (
        input  s_valid, s_data, s_sof, s_eol, m_ready,
        output s_ready, m_valid, m_data, m_x, m_y, m_inb
    );
    modport master (
        output s_valid, s_data, s_sof, s_eol, m_ready,
        input  s_ready, m_valid, m_data, m_x, m_y, m_inb
    );
endinterface

// File: rtl/image_translate_stream.sv
// image_translate_stream: raster stream translator with per-frame signed shifts and flag/drop/wrap modes
module image_translate_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CW         = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [CW:0] cfg_shift_x,
    input  logic signed [CW:0] cfg_shift_y,
    input  logic [1:0]         cfg_mode,
    image_translate_stream_if.slave bus,
    output logic               frame_err
);
    localparam int DW = CHANNELS * DATA_WIDTH;
    localparam logic [CW-1:0] X_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(IMG_HEIGHT - 1);
    localparam logic signed [CW+1:0] W_S = (CW+2)'(IMG_WIDTH);
    localparam logic signed [CW+1:0] H_S = (CW+2)'(IMG_HEIGHT);
    localparam logic [1:0] MODE_DROP = 2'd1;
    localparam logic [1:0] MODE_WRAP = 2'd2;

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nx;

    logic [CW-1:0]        x_cnt, y_cnt, bx, by, x_nx, y_nx;
    logic signed [CW:0]   lat_sx, lat_sy, use_sx, use_sy;
    logic [1:0]           lat_mode, use_mode;
    logic                 accept, take, err;
    logic                 s1_valid, s1_out, s2_free, s1_inb, s1_drop, s1_wrap;
    logic [DW-1:0]        s1_data;
    logic signed [CW+1:0] s1_sx, s1_sy;
    logic [1:0]           s1_mode;
    logic [CW-1:0]        s1_wx, s1_wy;

    assign accept      = bus.s_valid & bus.s_ready;
    assign take        = accept & (bus.s_sof | state == ACTIVE);
    assign s2_free     = !bus.m_valid | bus.m_ready;
    // A dropped beat leaves S1 without needing S2, so DROP never stalls the input
    assign s1_out      = s1_valid & (s1_drop | s2_free);
    assign bus.s_ready = !rst & (!s1_valid | s1_out);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        bx       = bus.s_sof ? '0 : x_cnt;
        by       = bus.s_sof ? '0 : y_cnt;
        use_sx   = bus.s_sof ? cfg_shift_x : lat_sx;
        use_sy   = bus.s_sof ? cfg_shift_y : lat_sy;
        use_mode = bus.s_sof ? cfg_mode : lat_mode;
        err      = take & ((bus.s_eol != (bx == X_LAST)) | (bus.s_sof & state == ACTIVE));
        x_nx     = bus.s_eol ? '0 : (bx == X_LAST ? bx : bx + 1'b1);
        y_nx     = bus.s_eol ? (by == Y_LAST ? '0 : by + 1'b1) : by;
        state_nx = state;
        if (take) state_nx = (bus.s_eol & by == Y_LAST) ? IDLE : ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            lat_sx    <= '0;
            lat_sy    <= '0;
            lat_mode  <= '0;
            frame_err <= 1'b0;
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_sx     <= '0;
            s1_sy     <= '0;
            s1_mode   <= '0;
        end else begin
            frame_err <= err;
            if (take) begin
                x_cnt <= x_nx;
                y_cnt <= y_nx;
            end
            if (take & bus.s_sof) begin
                lat_sx   <= cfg_shift_x;
                lat_sy   <= cfg_shift_y;
                lat_mode <= cfg_mode;
            end
            if (bus.s_ready) begin
                s1_valid <= take;
                if (take) begin
                    s1_data <= bus.s_data;
                    s1_sx   <= $signed({2'b00, bx}) + $signed({use_sx[CW], use_sx});
                    s1_sy   <= $signed({2'b00, by}) + $signed({use_sy[CW], use_sy});
                    s1_mode <= use_mode;
                end
            end
        end
    end

    // |shift| is below the image size, so a single add or subtract lands back in range
    always_comb begin
        s1_inb  = !s1_sx[CW+1] & (s1_sx < W_S) & !s1_sy[CW+1] & (s1_sy < H_S);
        s1_wrap = s1_mode == MODE_WRAP;
        s1_drop = s1_mode == MODE_DROP & !s1_inb;
        s1_wx   = CW'(s1_sx[CW+1] ? s1_sx + W_S : (s1_sx >= W_S ? s1_sx - W_S : s1_sx));
        s1_wy   = CW'(s1_sy[CW+1] ? s1_sy + H_S : (s1_sy >= H_S ? s1_sy - H_S : s1_sy));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_x     <= '0;
            bus.m_y     <= '0;
            bus.m_inb   <= 1'b0;
        end else if (s2_free) begin
            bus.m_valid <= s1_valid & !s1_drop;
            if (s1_valid & !s1_drop) begin
                bus.m_data <= s1_data;
                bus.m_x    <= s1_wrap ? s1_wx : s1_sx[CW-1:0];
                bus.m_y    <= s1_wrap ? s1_wy : s1_sy[CW-1:0];
                bus.m_inb  <= s1_wrap | s1_inb;
            end
        end
    end
endmodule

// File: tb/tb_image_translate_stream.sv
// tb_image_translate_stream: vector table, directed framing/reset sequences and randomized
// traffic checked against a queue-based model of the translation rules
module tb_image_translate_stream;
    localparam int DATA_WIDTH = 8;
    localparam int CHANNELS   = 3;
    localparam int DW         = DATA_WIDTH * CHANNELS;
    localparam int W          = 20;
    localparam int H          = 12;
    localparam int CW         = 5;
    localparam int MASK       = (1 << CW) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [CW:0] cfg_shift_x = '0;
    logic signed [CW:0] cfg_shift_y = '0;
    logic [1:0]         cfg_mode = '0;
    logic               frame_err;

    image_translate_stream_if #(.DATA_WIDTH(DATA_WIDTH), .CHANNELS(CHANNELS), .CW(CW)) bus ();

    image_translate_stream #(
        .DATA_WIDTH(DATA_WIDTH), .CHANNELS(CHANNELS), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_shift_x(cfg_shift_x), .cfg_shift_y(cfg_shift_y),
        .cfg_mode(cfg_mode), .bus(bus), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] d; int x; int y; bit inb; } beat_t;
    typedef struct { int shx; int shy; int mode; int px; int py; bit emit; int ex; int ey; bit einb; int tot; } vec_t;

    beat_t         exp_q[$];
    beat_t         b;
    vec_t          vt[13];
    int            total = 0, bad = 0, err_count = 0, emit_count = 0, ready_mode = 0;
    bit            in_frame = 0, err_pend = 0, hold = 0;
    int            mx, my, lsx, lsy, lmode;
    bit            cap_seen[256];
    int            cap_x[256], cap_y[256];
    bit            cap_inb[256];
    logic [DW-1:0] h_data;
    logic [CW-1:0] h_x, h_y;
    logic          h_inb;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: coordinates follow the raster position of each accepted beat within its frame
    function automatic void model_accept(input logic [DW-1:0] d, input bit sof, input bit eol);
        int bx, by, sx, sy;
        bit inb, err;
        beat_t nb;
        if (!in_frame && !sof) return;
        err = sof && in_frame;
        if (sof) begin
            mx = 0; my = 0; in_frame = 1;
            lsx = cfg_shift_x; lsy = cfg_shift_y; lmode = cfg_mode;
        end
        bx = mx; by = my;
        if (eol != (bx == W - 1)) err = 1;
        if (eol) begin
            mx = 0; my = by + 1;
            if (my == H) begin in_frame = 0; my = 0; end
        end else if (bx < W - 1) mx = bx + 1;
        sx = bx + lsx;
        sy = by + lsy;
        inb = sx >= 0 && sx < W && sy >= 0 && sy < H;
        err_pend = err;
        if (lmode == 1 && !inb) return;
        nb.d = d;
        nb.inb = inb || lmode == 2;
        nb.x = lmode == 2 ? ((sx % W) + W) % W : sx & MASK;
        nb.y = lmode == 2 ? ((sy % H) + H) % H : sy & MASK;
        exp_q.push_back(nb);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            in_frame = 0; err_pend = 0; hold = 0;
        end else begin
            check("frame_err", frame_err, err_pend);
            if (frame_err) err_count++;
            err_pend = 0;
            if (hold) begin
                check("stall_valid", bus.m_valid, 1);
                check("stall_stable", {bus.m_data, bus.m_x, bus.m_y, bus.m_inb}, {h_data, h_x, h_y, h_inb});
            end
            hold = bus.m_valid && !bus.m_ready;
            {h_data, h_x, h_y, h_inb} = {bus.m_data, bus.m_x, bus.m_y, bus.m_inb};
            if (bus.m_valid && bus.m_ready) begin
                emit_count++;
                cap_seen[bus.m_data[7:0]] = 1;
                cap_x[bus.m_data[7:0]] = bus.m_x;
                cap_y[bus.m_data[7:0]] = bus.m_y;
                cap_inb[bus.m_data[7:0]] = bus.m_inb;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: data %h x %0d y %0d with no beat expected", bus.m_data, bus.m_x, bus.m_y);
                end else begin
                    b = exp_q.pop_front();
                    check("out_data", bus.m_data, b.d);
                    check("out_x", bus.m_x, b.x);
                    check("out_y", bus.m_y, b.y);
                    check("out_inb", bus.m_inb, b.inb);
                end
            end
            if (bus.s_valid && bus.s_ready) model_accept(bus.s_data, bus.s_sof, bus.s_eol);
        end
    end

    always @(posedge clk) begin
        #1;
        bus.m_ready = ready_mode == 0 ? 1'b1 : ready_mode == 2 ? 1'b0 : 1'($urandom_range(1));
    end

    function automatic logic [DW-1:0] pix(input int idx);
        return {16'($urandom), 8'(idx)};
    endfunction

    task automatic rand_cfg();
        cfg_shift_x = (CW+1)'(int'($urandom_range(2 * W - 2)) - (W - 1));
        cfg_shift_y = (CW+1)'(int'($urandom_range(2 * H - 2)) - (H - 1));
        cfg_mode = 2'($urandom_range(3));
    endtask

    task automatic send(input logic [DW-1:0] d, input bit sof, input bit eol, input int gap, input bit rcfg);
        int n;
        n = 0;
        while (gap > 0 && $urandom_range(99) < gap) begin
            bus.s_valid = 1'b0;
            @(posedge clk); #1;
        end
        if (rcfg) rand_cfg();
        bus.s_valid = 1'b1; bus.s_data = d; bus.s_sof = sof; bus.s_eol = eol;
        forever begin
            @(negedge clk);
            if (bus.s_ready) break;
            n++;
            if (n > 500) begin
                total++; bad++;
                $display("FAIL accept_timeout: s_ready low for %0d cycles", n);
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "input stalled");
            end
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.s_eol = 1'b0;
    endtask

    task automatic send_line(input int y, input int len, input bit sof, input int gap, input bit rcfg);
        for (int x = 0; x < len; x++) send(pix(y * W + x), sof && x == 0, x == len - 1, gap, rcfg);
    endtask

    task automatic drain();
        int n;
        n = 0;
        repeat (4) @(negedge clk);
        while ((exp_q.size() != 0 || bus.m_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic clear_cap();
        foreach (cap_seen[i]) cap_seen[i] = 0;
        emit_count = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, idx, len;
        vt[0]  = '{5, 5, 0, 0, 0, 1, 5, 5, 1, 240};
        vt[1]  = '{5, 5, 0, 18, 0, 1, 23, 5, 0, 240};
        vt[2]  = '{-3, 0, 0, 0, 0, 1, 29, 0, 0, 240};
        vt[3]  = '{-10, 0, 1, 0, 0, 0, 0, 0, 0, 120};
        vt[4]  = '{-10, 0, 1, 10, 0, 1, 0, 0, 1, 120};
        vt[5]  = '{-10, 0, 1, 9, 4, 0, 0, 0, 0, 120};
        vt[6]  = '{8, -1, 2, 12, 0, 1, 0, 11, 1, 240};
        vt[7]  = '{8, -1, 2, 0, 1, 1, 8, 0, 1, 240};
        vt[8]  = '{-19, 11, 2, 0, 11, 1, 1, 10, 1, 240};
        vt[9]  = '{19, 0, 3, 1, 0, 1, 20, 0, 0, 240};
        vt[10] = '{0, -11, 0, 19, 11, 1, 19, 0, 1, 240};
        vt[11] = '{0, 11, 0, 19, 11, 1, 19, 22, 0, 240};
        vt[12] = '{3, -5, 1, 2, 6, 1, 5, 1, 1, 119};
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_sof = 1'b0; bus.s_eol = 1'b0;

        @(negedge clk);
        check("reset_s_ready", bus.s_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_m_valid", bus.m_valid, 0);
        check("reset_m_data", bus.m_data, 0);
        check("reset_m_xy", {bus.m_x, bus.m_y, bus.m_inb}, 0);
        check("reset_s_ready_after", bus.s_ready, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            clear_cap();
            cfg_shift_x = (CW+1)'(vt[i].shx);
            cfg_shift_y = (CW+1)'(vt[i].shy);
            cfg_mode = 2'(vt[i].mode);
            for (int y = 0; y < H; y++) send_line(y, W, y == 0, 0, 0);
            drain();
            idx = vt[i].py * W + vt[i].px;
            check($sformatf("vec%0d_emit", i), cap_seen[idx], vt[i].emit);
            if (vt[i].emit) begin
                check($sformatf("vec%0d_x", i), cap_x[idx], vt[i].ex);
                check($sformatf("vec%0d_y", i), cap_y[idx], vt[i].ey);
                check($sformatf("vec%0d_inb", i), cap_inb[idx], vt[i].einb);
            end
            check($sformatf("vec%0d_count", i), emit_count, vt[i].tot);
        end

        cfg_mode = 2'd0; cfg_shift_x = 6'sd1; cfg_shift_y = 6'sd2;
        send(pix(200), 1, 0, 0, 0);
        @(negedge clk);
        check("latency_1clk_valid", bus.m_valid, 0);
        @(negedge clk);
        check("latency_2clk_valid", bus.m_valid, 1);
        check("latency_x", bus.m_x, 1);
        check("latency_y", bus.m_y, 2);
        ready_mode = 2;
        @(posedge clk); #1;
        send(pix(201), 0, 0, 0, 0);
        send(pix(202), 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_s_ready", bus.s_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ready_mode = 0;
        @(negedge clk);
        check("midreset_m_valid", bus.m_valid, 0);
        check("midreset_s_ready_after", bus.s_ready, 1);
        @(posedge clk); #1;
        e0 = emit_count;
        for (int x = 3; x < 6; x++) send(pix(x), 0, x == 5, 0, 0);
        drain();
        check("no_sof_discard", emit_count, e0);

        clear_cap();
        e0 = err_count;
        cfg_shift_x = 6'sd2; cfg_shift_y = 6'sd0;
        send_line(0, W, 1, 0, 0);
        cfg_shift_x = 6'sd9;
        send_line(1, W - 1, 0, 0, 0);
        send_line(2, W, 0, 0, 0);
        send_line(3, W + 1, 0, 0, 0);
        for (int y = 4; y < H; y++) send_line(y, W, 0, 0, 0);
        drain();
        check("framing_err_count", err_count - e0, 2);
        check("midframe_cfg_ignored", cap_x[1 * W + 5], 7);
        clear_cap();
        for (int y = 0; y < H; y++) send_line(y, W, y == 0, 0, 0);
        drain();
        check("cfg_next_frame", cap_x[0], 9);

        clear_cap();
        e0 = err_count;
        cfg_shift_x = 6'sd3; cfg_shift_y = 6'sd4;
        for (int y = 0; y < 3; y++) send_line(y, W, y == 0, 0, 0);
        for (int x = 0; x < 5; x++) send(pix(3 * W + x), 0, 0, 0, 0);
        send(pix(250), 1, 0, 0, 0);
        for (int x = 1; x < W; x++) send(pix(x), 0, x == W - 1, 0, 0);
        for (int y = 1; y < H; y++) send_line(y, W, 0, 0, 0);
        drain();
        check("resync_err_count", err_count - e0, 1);
        check("resync_seen", cap_seen[250], 1);
        check("resync_x", cap_x[250], 3);
        check("resync_y", cap_y[250], 4);
        check("resync_next_x", cap_x[1], 4);

        ready_mode = 1;
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(1) == 1) send(pix(255), 0, 1'($urandom_range(1)), 10, 1);
            for (int y = 0; y < H; y++) begin
                len = $urandom_range(2) == 0 ? W - 1 + int'($urandom_range(2)) : W;
                send_line(y, len, y == 0, 30, 1);
            end
        end
        drain();
        ready_mode = 0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
